// File: rtl/equiv_miter_pkg.sv
// Shared definitions for the equivalence-miter sequencer.
//   state_e     : sequencer FSM states
//   SL_W*/SL_O* : widths/offsets of the five stimulus slices cut from the LFSR
//   LFSR_TAPS   : Galois feedback mask for x^78 + x^77 + x^72 + x^71 + 1
//   lfsr_step() : one right-shifting Galois step
package equiv_miter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int STIM_W = 78;

  localparam int SL_W0 = 12;
  localparam int SL_W1 = 12;
  localparam int SL_W2 = 14;
  localparam int SL_W3 = 22;
  localparam int SL_W4 = 18;

  localparam int SL_O0 = 0;
  localparam int SL_O1 = SL_O0 + SL_W0;
  localparam int SL_O2 = SL_O1 + SL_W1;
  localparam int SL_O3 = SL_O2 + SL_W2;
  localparam int SL_O4 = SL_O3 + SL_W3;

  // Tap n maps to mask bit n-1: bits 77, 76, 71, 70.
  localparam logic [STIM_W-1:0] LFSR_TAPS = 78'h30C0_0000_0000_0000_0000;

  function automatic logic [STIM_W-1:0] lfsr_step(input logic [STIM_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/equiv_lfsr78.sv
// 78-bit Galois LFSR stimulus source.
//   clk, rst : clock, async active-high reset (reset loads SEED)
//   load     : reload SEED (wins over step)
//   step     : advance one Galois step
//   state    : registered LFSR state
module equiv_lfsr78
  import equiv_miter_pkg::*;
#(
  parameter logic [STIM_W-1:0] SEED = 78'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  output logic [STIM_W-1:0] state
);

  // An all-zero state would lock the LFSR up, so substitute 1.
  localparam logic [STIM_W-1:0] SEED_EFF = (SEED == '0) ? 78'h1 : SEED;

  logic [STIM_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SEED_EFF;
    end else if (step) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/equiv_miter_sequencer.sv
// Equivalence-run sequencer: drives LFSR stimulus into both miter copies,
// compares y_1/y_2 LAT edges later, counts mismatches, captures the first.
//   clk, rst           : clock, async active-high reset
//   start, num_vectors : launch a run of num_vectors vectors (IDLE/DONE only)
//   y_1, y_2           : results of the two implementations
//   wire0..wire4       : stimulus slices of the registered LFSR state
//   busy, done, pass   : run status; pass valid while done
//   mismatch_count     : saturating mismatch count
//   first_fail_idx/vec : index and stimulus of the first mismatch
// Build option: EQUIV_STOP_ON_FAIL_EN ends the run at the first mismatch.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for start after reset
// ST_RUN   | issuing one vector per cycle
// ST_DRAIN | LAT cycles letting the last results arrive
// ST_DONE  | results held, start relaunches
module equiv_miter_sequencer
  import equiv_miter_pkg::*;
#(
  parameter int               OUT_W = 91,
  parameter int               LAT   = 1,
  parameter int               CNT_W = 16,
  parameter logic [STIM_W-1:0] SEED = 78'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vectors,
  input  logic [OUT_W-1:0]  y_1,
  input  logic [OUT_W-1:0]  y_2,
  output logic [11:0]       wire0,
  output logic [11:0]       wire1,
  output logic [13:0]       wire2,
  output logic [21:0]       wire3,
  output logic [17:0]       wire4,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [STIM_W-1:0] first_fail_vec
);

  localparam logic [3:0] DRAIN_INIT = 4'((LAT > 0) ? LAT - 1 : 0);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]    ffi_q, ffi_d;
  logic [STIM_W-1:0]   ffv_q, ffv_d;
  logic [3:0]          drain_q, drain_d;
  logic [STIM_W-1:0]   stim;
  logic                load, push_v, dly_v, miss;
  logic [CNT_W-1:0]    dly_idx;
  logic [STIM_W-1:0]   dly_vec;

  assign push_v = (state_q == ST_RUN);
  assign busy   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done   = (state_q == ST_DONE);
  assign pass   = done && (miss_cnt_q == '0);

  equiv_lfsr78 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (push_v),
    .state (stim)
  );

  assign wire0 = stim[SL_O0 +: SL_W0];
  assign wire1 = stim[SL_O1 +: SL_W1];
  assign wire2 = stim[SL_O2 +: SL_W2];
  assign wire3 = stim[SL_O3 +: SL_W3];
  assign wire4 = stim[SL_O4 +: SL_W4];

  // Delay line pairing each issued vector with its result LAT edges later.
  generate
    if (LAT == 0) begin : g_no_pipe
      assign dly_v   = push_v;
      assign dly_idx = idx_q;
      assign dly_vec = stim;
    end else begin : g_pipe
      logic [LAT-1:0]    v_q, v_d;
      logic [CNT_W-1:0]  i_q [LAT];
      logic [CNT_W-1:0]  i_d [LAT];
      logic [STIM_W-1:0] s_q [LAT];
      logic [STIM_W-1:0] s_d [LAT];

      always_comb begin
        v_d    = '0;
        i_d    = i_q;
        s_d    = s_q;
        v_d[0] = push_v;
        i_d[0] = idx_q;
        s_d[0] = stim;
        for (int k = 1; k < LAT; k++) begin
          v_d[k] = v_q[k-1];
          i_d[k] = i_q[k-1];
          s_d[k] = s_q[k-1];
        end
        // Leftovers from a stopped run must not be compared in the next one.
        if (load) v_d = '0;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= '0;
          for (int k = 0; k < LAT; k++) begin
            i_q[k] <= '0;
            s_q[k] <= '0;
          end
        end else begin
          v_q <= v_d;
          i_q <= i_d;
          s_q <= s_d;
        end
      end

      assign dly_v   = v_q[LAT-1];
      assign dly_idx = i_q[LAT-1];
      assign dly_vec = s_q[LAT-1];
    end
  endgenerate

  // Compares only count while a run is live; this discards the pipe after a stop.
  assign miss = dly_v && busy && (y_1 != y_2);

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    drain_d    = drain_q;
    miss_cnt_d = miss_cnt_q;
    ffi_d      = ffi_q;
    ffv_d      = ffv_q;
    load       = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          rem_d   = num_vectors;
          idx_d   = '0;
          state_d = (num_vectors == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        rem_d = rem_q - CNT_W'(1);
        idx_d = idx_q + CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = (LAT == 0) ? ST_DONE : ST_DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (miss) begin
      if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
      if (miss_cnt_q == '0) begin
        ffi_d = dly_idx;
        ffv_d = dly_vec;
      end
`ifdef EQUIV_STOP_ON_FAIL_EN
      state_d = ST_DONE;
`endif
    end

    if (load) begin
      miss_cnt_d = '0;
      ffi_d      = '0;
      ffv_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      idx_q      <= '0;
      drain_q    <= '0;
      miss_cnt_q <= '0;
      ffi_q      <= '0;
      ffv_q      <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      drain_q    <= drain_d;
      miss_cnt_q <= miss_cnt_d;
      ffi_q      <= ffi_d;
      ffv_q      <= ffv_d;
    end
  end

  assign mismatch_count = miss_cnt_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_equiv_miter_sequencer.sv
module tb_equiv_miter_sequencer;

`ifdef EQUIV_STOP_ON_FAIL_EN
  localparam int TB_LAT = 3;
`else
  localparam int TB_LAT = 1;
`endif
  localparam int OUT_W = 91;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic [OUT_W-1:0] y_1 = '0;
  logic [OUT_W-1:0] y_2 = '0;
  logic [11:0]      wire0, wire1;
  logic [13:0]      wire2;
  logic [21:0]      wire3;
  logic [17:0]      wire4;
  logic             busy, done, pass;
  logic [CNT_W-1:0] mismatch_count, first_fail_idx;
  logic [77:0]      first_fail_vec;

  int n_vec  = 0;
  int n_miss = 0;

  equiv_miter_sequencer #(
    .OUT_W (OUT_W),
    .LAT   (TB_LAT),
    .CNT_W (CNT_W),
    .SEED  (78'h1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_vectors    (num_vectors),
    .y_1            (y_1),
    .y_2            (y_2),
    .wire0          (wire0),
    .wire1          (wire1),
    .wire2          (wire2),
    .wire3          (wire3),
    .wire4          (wire4),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_count (mismatch_count),
    .first_fail_idx (first_fail_idx),
    .first_fail_vec (first_fail_vec)
  );

  always #5 clk = ~clk;

  // Model: golden stimulus sequence plus the current run's parameters.
  logic [77:0] gold [0:255];
  bit m_active = 1'b0;
  int m_cyc = 0, m_n = 0, m_mode = 0, m_fidx = 0;
  bit p_start = 1'b0;
  int p_n = 0, p_mode = 0, p_fidx = 0;
  bit check_en = 1'b0;
  bit pin_en = 1'b0;

  function automatic logic [77:0] lfsr_next(input logic [77:0] s);
    logic [77:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[77] = ~n[77];
      n[76] = ~n[76];
      n[71] = ~n[71];
      n[70] = ~n[70];
    end
    return n;
  endfunction

  // mode 0: no fault, 1: only index fidx, 2: every index from fidx on
  function automatic bit is_fault(input int idx);
    if (m_mode == 1) return idx == m_fidx;
    if (m_mode == 2) return idx >= m_fidx;
    return 1'b0;
  endfunction

  function automatic int first_fault();
    for (int i = 0; i < m_n; i++) if (is_fault(i)) return i;
    return -1;
  endfunction

  function automatic bit stops();
`ifdef EQUIV_STOP_ON_FAIL_EN
    return first_fault() >= 0;
`else
    return 1'b0;
`endif
  endfunction

  // First cycle (counted from the accepting edge) in which done is high.
  function automatic int end_cyc();
    if (m_n == 0) return 0;
    if (stops()) return first_fault() + TB_LAT + 1;
    return m_n + TB_LAT;
  endfunction

  // Number of vectors actually issued (LFSR steps taken).
  function automatic int run_cycles();
    int s;
    if (m_n == 0) return 0;
    if (stops()) begin
      s = first_fault() + TB_LAT + 1;
      return (s < m_n) ? s : m_n;
    end
    return m_n;
  endfunction

  function automatic bit exp_busy();
    return m_active && (m_cyc < end_cyc());
  endfunction

  task automatic check(input string name, input logic [90:0] act, input logic [90:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic drive_y();
    int idx;
    idx = m_cyc - TB_LAT;
    if (m_active && idx >= 0 && idx < m_n) begin
      y_1 = {13'd0, gold[idx]};
      y_2 = y_1 ^ (is_fault(idx) ? 91'd1 : 91'd0);
    end else begin
      y_1 = '0;
      y_2 = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (p_start) begin
      m_active = 1'b1;
      m_cyc    = 0;
      m_n      = p_n;
      m_mode   = p_mode;
      m_fidx   = p_fidx;
      p_start  = 1'b0;
    end else if (m_active) begin
      m_cyc++;
    end
    start = 1'b0;
    drive_y();
  endtask

  task automatic launch(input int n, input int mode, input int fidx);
    start       = 1'b1;
    num_vectors = CNT_W'(n);
    p_start     = !exp_busy() && !rst;
    p_n         = n;
    p_mode      = mode;
    p_fidx      = fidx;
    tick();
  endtask

  task automatic wait_done(input int budget, output int busy_cycles);
    int k;
    k = 0;
    busy_cycles = 0;
    while (!done && k < budget) begin
      if (busy) busy_cycles++;
      if (pin_en && m_cyc == 1) check("pin_wire4_step1", 91'(wire4), 91'h30C00);
      if (pin_en && m_cyc == 2) check("pin_wire4_step2", 91'(wire4), 91'h18600);
      tick();
      k++;
    end
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL wait_done: done still %0b after %0d cycles", done, budget);
    end
  endtask

  task automatic compare_all();
    int f, last, cnt, r, e_end;
    logic [77:0] w_exp;
    f     = first_fault();
    e_end = end_cyc();
    r     = run_cycles();
    cnt   = 0;
    if (m_active) begin
      last = m_cyc - TB_LAT - 1;
      if (last > m_n - 1) last = m_n - 1;
      for (int i = 0; i <= last; i++) if (is_fault(i)) cnt++;
      if (stops() && cnt > 1) cnt = 1;
    end
    w_exp = !m_active ? gold[0] : gold[(m_cyc < r) ? m_cyc : r];
    check("busy", 91'(busy), 91'(m_active && m_cyc < e_end));
    check("done", 91'(done), 91'(m_active && m_cyc >= e_end));
    check("pass", 91'(pass), 91'(m_active && m_cyc >= e_end && cnt == 0));
    check("stimulus", 91'({wire4, wire3, wire2, wire1, wire0}), 91'(w_exp));
    check("mismatch_count", 91'(mismatch_count), 91'(cnt));
    check("first_fail_idx", 91'(first_fail_idx), 91'((cnt > 0) ? f : 0));
    check("first_fail_vec", 91'(first_fail_vec), 91'((cnt > 0) ? gold[f] : 78'h0));
  endtask

  always @(negedge clk) begin
    if (check_en) compare_all();
  end

  initial begin
    int bc, exp_done_cyc, exp_cnt;
    gold[0] = 78'h1;
    for (int i = 1; i < 256; i++) gold[i] = lfsr_next(gold[i-1]);

    // Reset then idle
    rst = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("idle_busy", 91'(busy), 91'd0);
    check("idle_done", 91'(done), 91'd0);
    check("idle_wire0", 91'(wire0), 91'h001);
    check("idle_wire4", 91'(wire4), 91'h0);
    check("idle_count", 91'(mismatch_count), 91'd0);

    // Clean run, 100 vectors, then a second identical run
    pin_en = 1'b1;
    launch(100, 0, 0);
    wait_done(500, bc);
    pin_en = 1'b0;
    check("clean_busy_cycles", 91'(bc), 91'(100 + TB_LAT));
    check("clean_pass", 91'(pass), 91'd1);
    check("clean_count", 91'(mismatch_count), 91'd0);
    tick();
    launch(100, 0, 0);
    wait_done(500, bc);
    check("clean2_busy_cycles", 91'(bc), 91'(100 + TB_LAT));
    check("clean2_pass", 91'(pass), 91'd1);

    // Single injected fault at index 37 of 64
    launch(64, 1, 37);
    wait_done(500, bc);
    check("fault37_pass", 91'(pass), 91'd0);
    check("fault37_count", 91'(mismatch_count), 91'd1);
    check("fault37_idx", 91'(first_fail_idx), 91'd37);
    check("fault37_vec", 91'(first_fail_vec), 91'(gold[37]));

    // Zero-length run
    tick();
    launch(0, 0, 0);
    check("zero_done", 91'(done), 91'd1);
    check("zero_pass", 91'(pass), 91'd1);
    check("zero_busy", 91'(busy), 91'd0);
    check("zero_wire0", 91'(wire0), 91'h001);
    tick();

    // Abort by reset at vector 20 of 50, fault at 10
    launch(50, 1, 10);
    for (int k = 0; k < 60 && m_cyc < 20; k++) tick();
    check("abort_pre_count", 91'(mismatch_count), 91'd1);
    rst      = 1'b1;
    m_active = 1'b0;
    p_start  = 1'b0;
    drive_y();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("abort_count", 91'(mismatch_count), 91'd0);
    check("abort_idx", 91'(first_fail_idx), 91'd0);
    check("abort_busy", 91'(busy), 91'd0);
    check("abort_wire0", 91'(wire0), 91'h001);
    launch(10, 0, 0);
    wait_done(200, bc);
    check("fresh_pass", 91'(pass), 91'd1);

    // Persistent fault from index 5 of 50, with a start pulse while busy
    tick();
    launch(50, 2, 5);
    tick();
    tick();
    tick();
    launch(7, 0, 0);
    wait_done(500, bc);
`ifdef EQUIV_STOP_ON_FAIL_EN
    exp_done_cyc = 9;
    exp_cnt      = 1;
`else
    exp_done_cyc = 51;
    exp_cnt      = 45;
`endif
    check("persist_done_cycle", 91'(m_cyc), 91'(exp_done_cyc));
    check("persist_count", 91'(mismatch_count), 91'(exp_cnt));
    check("persist_idx", 91'(first_fail_idx), 91'd5);
    check("persist_vec", 91'(first_fail_vec), 91'(gold[5]));
    check("persist_pass", 91'(pass), 91'd0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/equiv_miter_sequencer.md
Name: equiv_miter_sequencer

Overview:
Sequences a two-implementation equivalence run. Generates pseudo-random stimulus from an LFSR and drives it identically into both DUT copies of the miter. Compares the two 91-bit results after a configurable latency, counts mismatches and captures the first failing vector. Sits beside the miter top and replaces free-running formal inputs with a bounded, reproducible simulation campaign.

Parameters:
OUT_W, 91, width of each DUT result (y_1/y_2)
LAT, 1, clk edges from stimulus presentation to valid DUT result; legal range 0..15
CNT_W, 16, width of vector count, index and mismatch counters
SEED, 78'h1, LFSR reload value; must be nonzero (a zero value is replaced by 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse that launches a run; honoured in IDLE or DONE only
num_vectors  in  CNT_W  vectors per run, sampled on accepted start
y_1  in  OUT_W  result of implementation 1
y_2  in  OUT_W  result of implementation 2
wire0  out  12  stimulus, LFSR bits [11:0]
wire1  out  12  stimulus, LFSR bits [23:12]
wire2  out  14  stimulus, LFSR bits [37:24]
wire3  out  22  stimulus, LFSR bits [59:38]
wire4  out  18  stimulus, LFSR bits [77:60]
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE; held until the next accepted start
pass  out  1  valid when done=1; 1 if mismatch_count==0
mismatch_count  out  CNT_W  saturating count of compared mismatches
first_fail_idx  out  CNT_W  index of the first mismatching vector
first_fail_vec  out  78  stimulus of the first mismatching vector

Behaviour:
- Reset: all outputs 0, except pass=0 and wire0..wire4 = SEED slices. State is IDLE, the LFSR reloads SEED and the valid/index pipeline clears. Reset asserted mid-run aborts the run immediately with no residual compares.
- The LFSR is a 78-bit Galois LFSR with taps 78,77,72,71 and advances one step per issued vector. The stimulus outputs are the registered LFSR state.
- States:
  - IDLE: on start, load remaining=num_vectors, clear counters and capture registers, reload the LFSR with SEED. Go to RUN, or to DONE with pass=1 when num_vectors==0.
  - RUN: each cycle presents one vector, tags it with index 0..N-1 and pushes valid=1 into a LAT-deep pipe, then advances the LFSR. After vector N-1 is presented, go to DRAIN.
  - DRAIN: LAT cycles with no new vectors, then DONE. With LAT=0, DRAIN lasts 0 cycles and the FSM goes straight to DONE.
  - DONE: done=1, pass=(mismatch_count==0). start returns to the IDLE load path in the same edge.
- Compare: at the rising edge where the delayed valid is 1, evaluate y_1!=y_2.
  - On a mismatch, increment mismatch_count, saturating at all-ones.
  - On the first mismatch of a run only, capture first_fail_idx and first_fail_vec from the delayed index/stimulus pipe.
- start while busy is ignored. start and reset together: reset wins.
- The last vector's compare and the transition to DONE occur on the same edge, so its mismatch is reflected in pass.
- The stimulus outputs hold their last value outside RUN.

Optional Feature:
EQUIV_STOP_ON_FAIL_EN
- Defined: the first mismatch forces the FSM to DONE on the next edge. Vectors still in the pipe are discarded and not compared; mismatch_count=1, pass=0.
- Undefined: the run always completes all num_vectors compares.

Decomposition:
- Package equiv_miter_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - stimulus slice width/offset localparams (12,12,14,22,18; total 78);
  - the LFSR tap constant.
- Sub-module equiv_lfsr78 provides the LFSR with load/step controls. The index/valid/stimulus delay line stays inline.

Test Plan:
- Reset then idle: rst high 3 cycles, then low, no start -> busy=0, done=0, wire0..wire4 equal SEED slices, mismatch_count=0.
- Clean run: identical DUTs, LAT=1, num_vectors=100 -> busy high exactly 101 cycles, done=1, pass=1, mismatch_count=0. The second run reproduces the identical stimulus sequence.
- Injected fault: y_2 = y_1 ^ 1 only when index==37, num_vectors=64 -> pass=0, mismatch_count=1, first_fail_idx=37, first_fail_vec equals vector 37 of the golden LFSR model.
- Zero-length run: num_vectors=0 -> DONE one cycle after start, pass=1, no stimulus change.
- Abort: assert rst at vector 20 of a 50-vector run with a fault at index 10 -> all counters 0, state IDLE. A new start gives a fresh run with the LFSR reloaded.
- Stop-on-fail (EQUIV_STOP_ON_FAIL_EN): persistent mismatch from index 5, LAT=3, num_vectors=50 -> done on the cycle after the index-5 compare, mismatch_count=1, first_fail_idx=5; start during busy is ignored.
